cc_unit: RTL and testbench

Execute-stage condition-code unit for the Y86-64 pipeline: sits directly downstream of the 64-bit ALU adder and consumes its result. It derives ZF/SF/OF from the ALU result and operands and holds them in the architectural condition-code register. It evaluates the jXX/cmovXX condition (`e_cnd`) for the instruction currently in Execute. Updates are suppressed when a later stage carries an exception.

---
 rtl/y86_pkg.sv | 26 ++
 rtl/cond_eval.sv | 30 +++
 rtl/cc_unit.sv | 74 +++++++
 tb/tb_cc_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: ALU function codes, jXX/cmovXX condition codes,
// and the condition-code register layout.
package y86_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_XOR = 4'd3;

    localparam logic [3:0] C_ALWAYS = 4'd0;
    localparam logic [3:0] C_LE     = 4'd1;
    localparam logic [3:0] C_L      = 4'd2;
    localparam logic [3:0] C_E      = 4'd3;
    localparam logic [3:0] C_NE     = 4'd4;
    localparam logic [3:0] C_GE     = 4'd5;
    localparam logic [3:0] C_G      = 4'd6;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

endpackage

// File: rtl/cond_eval.sv
// Combinational jXX/cmovXX condition evaluator over a set of condition codes.
// Undefined condition codes evaluate false.
module cond_eval
    import y86_pkg::*;
(
    input  logic       zf,
    input  logic       sf,
    input  logic       of,
    input  logic [3:0] cond_fun,
    output logic       cnd
);

    logic less;

    always_comb begin
        less = sf ^ of;
        cnd  = 1'b0;
        case (cond_fun)
            C_ALWAYS: cnd = 1'b1;
            C_LE:     cnd = less | zf;
            C_L:      cnd = less;
            C_E:      cnd = zf;
            C_NE:     cnd = ~zf;
            C_GE:     cnd = ~less;
            C_G:      cnd = ~less & ~zf;
            default:  cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/cc_unit.sv
// Execute-stage condition-code register: derives ZF/SF/OF from the ALU result,
// gates the write on downstream exceptions, and evaluates the Execute condition.
module cc_unit
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] alu_a,
    input  logic [W-1:0] alu_b,
    input  logic [3:0]   alu_fun,
    input  logic [W-1:0] val_e,
    input  logic         set_cc_req,
    input  logic         m_exc,
    input  logic         w_exc,
    input  logic [3:0]   cond_fun,
    output logic         zf,
    output logic         sf,
    output logic         of,
    output logic         e_cnd,
    output logic         cc_updated
);

    cc_t  cc_reg;
    cc_t  cc_next;
    logic cc_updated_reg;
    logic set_cc;

    // Overflow only depends on the sign bits; the rest of each operand is unused.
    logic unused_operand_bits;
    assign unused_operand_bits = &{1'b0, alu_a[W-2:0], alu_b[W-2:0]};

    // A faulting instruction further down the pipe must not leave visible CC state.
    assign set_cc = set_cc_req & ~m_exc & ~w_exc;

    always_comb begin
        cc_next.zf = (val_e == '0);
        cc_next.sf = val_e[W-1];
        cc_next.of = 1'b0;
        case (alu_fun)
            ALU_ADD: cc_next.of = (alu_a[W-1] == alu_b[W-1]) & (val_e[W-1] != alu_a[W-1]);
            ALU_SUB: cc_next.of = (alu_a[W-1] != alu_b[W-1]) & (val_e[W-1] != alu_b[W-1]);
            default: cc_next.of = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cc_reg         <= CC_RESET;
            cc_updated_reg <= 1'b0;
        end else begin
            if (set_cc) begin
                cc_reg <= cc_next;
            end
            cc_updated_reg <= set_cc;
        end
    end

    assign zf         = cc_reg.zf;
    assign sf         = cc_reg.sf;
    assign of         = cc_reg.of;
    assign cc_updated = cc_updated_reg;

    // Consumers in Execute see the flags as they stood before this cycle's write.
    cond_eval u_cond_eval (
        .zf       (cc_reg.zf),
        .sf       (cc_reg.sf),
        .of       (cc_reg.of),
        .cond_fun (cond_fun),
        .cnd      (e_cnd)
    );

endmodule

// File: tb/tb_cc_unit.sv
// Scoreboard bench for cc_unit: a driver issues one transaction per cycle and
// pushes the reference result; a monitor pops and compares after each edge.
module tb_cc_unit;

    localparam int W = 64;
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ALL_ONE = {W{1'b1}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] alu_a = '0;
    logic [W-1:0] alu_b = '0;
    logic [3:0]   alu_fun = 4'd0;
    logic [W-1:0] val_e = '0;
    logic         set_cc_req = 1'b0;
    logic         m_exc = 1'b0;
    logic         w_exc = 1'b0;
    logic [3:0]   cond_fun = 4'd0;
    logic         zf, sf, of, e_cnd, cc_updated;

    typedef struct {
        int   id;
        logic zf;
        logic sf;
        logic of;
        logic upd;
        logic cnd;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn_id = 0;
    logic m_zf = 1'b1;
    logic m_sf = 1'b0;
    logic m_of = 1'b0;

    cc_unit #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_fun    (alu_fun),
        .val_e      (val_e),
        .set_cc_req (set_cc_req),
        .m_exc      (m_exc),
        .w_exc      (w_exc),
        .cond_fun   (cond_fun),
        .zf         (zf),
        .sf         (sf),
        .of         (of),
        .e_cnd      (e_cnd),
        .cc_updated (cc_updated)
    );

    always #5 clk = ~clk;

    // Branch semantics: "less" means the signed result was negative after
    // accounting for overflow.
    function automatic logic cond_ref(input logic z, input logic s, input logic o,
                                      input logic [3:0] c);
        logic less;
        less = s ^ o;
        case (c)
            4'd0:    return 1'b1;
            4'd1:    return less || z;
            4'd2:    return less;
            4'd3:    return z;
            4'd4:    return !z;
            4'd5:    return !less;
            4'd6:    return !less && !z;
            default: return 1'b0;
        endcase
    endfunction

    // True ALU output for the four defined functions.
    function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [3:0] f);
        case (f)
            4'd0:    return b + a;
            4'd1:    return b - a;
            4'd2:    return b & a;
            default: return b ^ a;
        endcase
    endfunction

    // Overflow as "exact signed result does not fit in W bits".
    function automatic logic of_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [3:0] f);
        logic signed [W:0] sa, sb, exact, lo, hi;
        sa = $signed(a);
        sb = $signed(b);
        lo = $signed(MIN_NEG);
        hi = $signed(MAX_POS);
        if (f == 4'd0) exact = sb + sa;
        else if (f == 4'd1) exact = sb - sa;
        else return 1'b0;
        return (exact < lo) || (exact > hi);
    endfunction

    task automatic txn(input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] v, input logic [3:0] f, input logic req,
                       input logic me, input logic we, input logic [3:0] c);
        exp_t e;
        logic upd;
        @(negedge clk);
        rst = r; alu_a = a; alu_b = b; val_e = v; alu_fun = f;
        set_cc_req = req; m_exc = me; w_exc = we; cond_fun = c;
        upd = 1'b0;
        if (r) begin
            m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
        end else if (req && !me && !we) begin
            upd  = 1'b1;
            m_zf = (v == 0);
            m_sf = ($signed(v) < 0);
            m_of = of_ref(a, b, f);
        end
        e.id = txn_id; e.zf = m_zf; e.sf = m_sf; e.of = m_of; e.upd = upd;
        e.cnd = cond_ref(m_zf, m_sf, m_of, c);
        sb_q.push_back(e);
        txn_id++;
    endtask

    task automatic opq(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] f,
                       input logic me, input logic we, input logic [3:0] c);
        txn(1'b0, a, b, alu_ref(a, b, f), f, 1'b1, me, we, c);
    endtask

    task automatic idle(input logic [3:0] c);
        txn(1'b0, '0, '0, ALL_ONE, 4'd0, 1'b0, 1'b0, 1'b0, c);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return MAX_POS;
            2:       return MIN_NEG;
            3:       return ALL_ONE;
            4:       return W'($urandom_range(0, 8));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Monitor: every cycle with an outstanding expectation, compare just after the edge.
    initial begin
        exp_t e;
        int   bad;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                bad = 0;
                checks += 5;
                if (zf !== e.zf) begin
                    errors++; bad++;
                    $display("FAIL txn%0d zf: got %b want %b", e.id, zf, e.zf);
                end
                if (sf !== e.sf) begin
                    errors++; bad++;
                    $display("FAIL txn%0d sf: got %b want %b", e.id, sf, e.sf);
                end
                if (of !== e.of) begin
                    errors++; bad++;
                    $display("FAIL txn%0d of: got %b want %b", e.id, of, e.of);
                end
                if (cc_updated !== e.upd) begin
                    errors++; bad++;
                    $display("FAIL txn%0d cc_updated: got %b want %b", e.id, cc_updated, e.upd);
                end
                if (e_cnd !== e.cnd) begin
                    errors++; bad++;
                    $display("FAIL txn%0d e_cnd(cond_fun=%0d): got %b want %b",
                             e.id, cond_fun, e_cnd, e.cnd);
                end
                if (bad == 0)
                    $display("txn%0d ok: zf=%b sf=%b of=%b upd=%b cond_fun=%0d e_cnd=%b",
                             e.id, zf, sf, of, cc_updated, cond_fun, e_cnd);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a, b, v;
        logic [3:0]   f;
        logic         r, req, me, we;

        // Reset held two cycles; e_cnd for "e" follows the reset ZF.
        txn(1'b1, '0, '0, '0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd3);
        txn(1'b1, '0, '0, '0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd3);

        // ADD overflow, then "l" sees sf^of = 0.
        opq(64'd1, MAX_POS, 4'd0, 1'b0, 1'b0, 4'd2);
        idle(4'd2);

        // SUB to zero, then "e" and "g".
        opq(64'd5, 64'd5, 4'd1, 1'b0, 1'b0, 4'd3);
        idle(4'd6);

        // Establish zf=0 sf=1 of=0, then exceptions suppress an XOR-to-zero.
        opq('0, MIN_NEG, 4'd3, 1'b0, 1'b0, 4'd0);
        opq(64'h1234, 64'h1234, 4'd3, 1'b1, 1'b0, 4'd3);
        opq(64'h1234, 64'h1234, 4'd3, 1'b0, 1'b1, 4'd3);
        opq(64'h1234, 64'h1234, 4'd3, 1'b1, 1'b1, 4'd3);

        // Reset dominates a simultaneous write.
        txn(1'b1, '0, '0, ALL_ONE, 4'd3, 1'b1, 1'b0, 1'b0, 4'd3);
        idle(4'd1);

        // Condition sweep over every reachable flag combination.
        for (int k = 0; k < 6; k++) begin
            case (k)
                0: opq(64'h5, 64'h5, 4'd3, 1'b0, 1'b0, 4'd0);        // z=1 s=0 o=0
                1: opq(64'h1, 64'h0, 4'd3, 1'b0, 1'b0, 4'd0);        // z=0 s=0 o=0
                2: opq('0, MIN_NEG, 4'd3, 1'b0, 1'b0, 4'd0);         // z=0 s=1 o=0
                3: opq(64'd1, MAX_POS, 4'd0, 1'b0, 1'b0, 4'd0);      // z=0 s=1 o=1
                4: opq(MIN_NEG + 1, MIN_NEG, 4'd0, 1'b0, 1'b0, 4'd0); // z=0 s=0 o=1
                default: opq(MIN_NEG, MIN_NEG, 4'd0, 1'b0, 1'b0, 4'd0); // z=1 s=0 o=1
            endcase
            for (int c = 0; c < 16; c++) idle(4'(c));
        end

        // Back-to-back writes with random operands and undefined ALU codes.
        for (int n = 0; n < 400; n++) begin
            a   = pick_operand();
            b   = pick_operand();
            f   = 4'($urandom_range(0, 5));
            v   = (f < 4'd4) ? alu_ref(a, b, f) : pick_operand();
            r   = ($urandom_range(0, 49) == 0);
            req = ($urandom_range(0, 9) < 7);
            me  = ($urandom_range(0, 9) < 2);
            we  = ($urandom_range(0, 9) < 2);
            txn(r, a, b, v, f, req, me, we, 4'($urandom_range(0, 15)));
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
